// File: rtl/tdc_multi.sv
// rtl/tdc_multi.sv - multi-channel TDC: pulse sync, edge detect, interval records via FIFO.
// Optional TDC_DROP_CNT_EN builds the saturating 16-bit dropped-record counter.
module tdc_multi #(
  parameter int N_CH         = 2,
  parameter int CNT_W        = 7,
  parameter int MAX_INTERVAL = 127,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  pulse,
  output logic [N_CH-1:0]  rec_start,
  output logic [N_CH-1:0]  rec_end,
  output logic [CNT_W-1:0] rec_interval,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             overflow,
  output logic [15:0]      drop_count
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int REC_W = 2 * N_CH + CNT_W;

  typedef enum logic {IDLE, ARMED} state_t;

  logic [N_CH-1:0]  s1, s2, s3;
  logic [N_CH-1:0]  hit;
  logic             is_event, is_multi, timeout;
  state_t           state, next_state;
  logic [N_CH-1:0]  start_q, start_d;
  logic [CNT_W-1:0] count, count_d;
  logic             rec_wr;
  logic [REC_W-1:0] rec_d;

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fill;
  logic             full, rd_en, wr_en, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= pulse;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign hit      = s2 & ~s3;
  assign is_event = |hit;
  // More than one bit set means several channels coincided.
  assign is_multi = |(hit & (hit - N_CH'(1)));
  assign timeout  = (state == ARMED) && (count >= CNT_W'(MAX_INTERVAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= '0;
      count   <= '0;
    end else begin
      state   <= next_state;
      start_q <= start_d;
      count   <= count_d;
    end
  end

  always_comb begin
    next_state = state;
    start_d    = start_q;
    count_d    = count;
    rec_wr     = 1'b0;
    rec_d      = '0;
    if (is_event) begin
      next_state = ARMED;
      start_d    = hit;
      count_d    = '0;
      if (is_multi) begin
        rec_wr = 1'b1;
        rec_d  = {N_CH'(0), hit, CNT_W'(0)};
      end else if (state == ARMED && !timeout) begin
        rec_wr = 1'b1;
        rec_d  = {start_q, hit, count + CNT_W'(1)};
      end
    end else if (state == ARMED) begin
      // The window has expired once count sits at MAX_INTERVAL.
      if (timeout) next_state = IDLE;
      else         count_d    = count + CNT_W'(1);
    end
  end

  assign full      = (fill == (AW+1)'(FIFO_DEPTH));
  assign rec_valid = (fill != '0);
  assign rd_en     = rec_valid & rec_ready;
  assign wr_en     = rec_wr & (~full | rd_en);
  assign drop      = rec_wr & full & ~rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= rec_d;
        wr_ptr      <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (wr_en && !rd_en)      fill <= fill + (AW+1)'(1);
      else if (rd_en && !wr_en) fill <= fill - (AW+1)'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign {rec_start, rec_end, rec_interval} = mem[rd_ptr];

`ifdef TDC_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != '1)   drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_tdc_multi.sv
// tb/tb_tdc_multi.sv - scoreboard bench for tdc_multi with default parameters.
`timescale 1ns/100ps
module tb_tdc_multi;

  localparam int N_CH  = 2;
  localparam int CNT_W = 7;
  localparam int REC_W = 2 * N_CH + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_CH-1:0]  pulse = '0;
  logic [N_CH-1:0]  rec_start, rec_end;
  logic [CNT_W-1:0] rec_interval;
  logic             rec_valid;
  logic             rec_ready = 1'b1;
  logic             overflow;
  logic [15:0]      drop_count;

  int vectors = 0;
  int miscompares = 0;
  logic [REC_W-1:0] exp_q [$];

  tdc_multi dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse        (pulse),
    .rec_start    (rec_start),
    .rec_end      (rec_end),
    .rec_interval (rec_interval),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #1 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] rec(input logic [1:0] s, input logic [1:0] e,
                                           input logic [6:0] i);
    return {s, e, i};
  endfunction

  always @(negedge clk) begin
    #0.5;
    if (rst_n && rec_valid && rec_ready) begin
      if (exp_q.size() == 0)
        check_val("extra_rec", 32'(exp_q.size()), 32'd1);
      else
        check_val("rec", 32'({rec_start, rec_end, rec_interval}), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise mask for one cycle; the next fire starts gap cycles after this one.
  task automatic fire(input logic [1:0] m, input int gap);
    @(negedge clk) pulse = m;
    @(negedge clk) pulse = '0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic check_outs_zero(input string tag);
    check_val(tag, 32'({rec_start, rec_end, rec_interval, rec_valid, overflow, drop_count}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    rec_ready = 1'b1;
    pulse = '0;
    exp_q.delete();
    tick(3);
    #0.5 check_outs_zero("reset_outs");
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_drop;
`ifdef TDC_DROP_CNT_EN
    exp_drop = 16'd1;
`else
    exp_drop = 16'd0;
`endif
    tick(3);
    #0.5 check_outs_zero("init_reset");
    @(negedge clk) rst_n = 1'b1;
    tick(2);

    // Single pair, 10-cycle gap.
    exp_q.push_back(rec(2'b01, 2'b10, 7'd10));
    fire(2'b01, 10);
    fire(2'b10, 2);
    tick(10);
    check_val("s1_left", 32'(exp_q.size()), 32'd0);

    // Coincidence then a single-channel follow-up.
    do_reset();
    exp_q.push_back(rec(2'b00, 2'b11, 7'd0));
    exp_q.push_back(rec(2'b11, 2'b01, 7'd5));
    fire(2'b11, 5);
    fire(2'b01, 2);
    tick(10);
    check_val("s2_left", 32'(exp_q.size()), 32'd0);

    // Window edge: 127 fits, 128 times out and the late hit becomes the start.
    do_reset();
    exp_q.push_back(rec(2'b01, 2'b10, 7'd127));
    fire(2'b01, 127);
    fire(2'b10, 2);
    tick(200);
    check_val("s3a_left", 32'(exp_q.size()), 32'd0);
    fire(2'b01, 128);
    exp_q.push_back(rec(2'b10, 2'b01, 7'd3));
    fire(2'b10, 3);
    fire(2'b01, 2);
    tick(10);
    check_val("s3b_left", 32'(exp_q.size()), 32'd0);

    // Backpressure: 5 records into a 4-deep FIFO.
    do_reset();
    rec_ready = 1'b0;
    exp_q.push_back(rec(2'b01, 2'b10, 7'd2));
    exp_q.push_back(rec(2'b10, 2'b01, 7'd2));
    exp_q.push_back(rec(2'b01, 2'b10, 7'd2));
    exp_q.push_back(rec(2'b10, 2'b01, 7'd2));
    for (int i = 0; i < 6; i++) fire((i % 2 == 0) ? 2'b01 : 2'b10, 2);
    tick(10);
    #0.5;
    check_val("ovf_flag", 32'(overflow), 32'd1);
    check_val("ovf_drop", 32'(drop_count), 32'(exp_drop));
    check_val("ovf_valid", 32'(rec_valid), 32'd1);
    check_val("ovf_held", 32'(exp_q.size()), 32'd4);
    @(negedge clk) rec_ready = 1'b1;
    tick(10);
    check_val("ovf_drained", 32'(exp_q.size()), 32'd0);
    #0.5 check_val("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-window loses the pending start.
    do_reset();
    fire(2'b01, 6);
    rst_n = 1'b0;
    tick(2);
    #0.5 check_outs_zero("mid_reset_outs");
    @(negedge clk) rst_n = 1'b1;
    fire(2'b10, 2);
    tick(10);
    #0.5 check_val("mid_reset_norec", 32'(rec_valid), 32'd0);

    // Back-to-back 1-cycle pulses every 2 cycles.
    do_reset();
    for (int i = 0; i < 7; i++) exp_q.push_back(rec(2'b01, 2'b01, 7'd2));
    for (int i = 0; i < 8; i++) fire(2'b01, 2);
    tick(10);
    check_val("burst_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
